// File: rtl/es_bs_pkg.sv
// Shared types and sizing helpers for the ordered stochastic-computing datapath.
package es_bs_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} es_gen_state_t;

  localparam int ES_DATA_WIDTH = 5;
  localparam int ES_NUM_INPUTS = 2;
  localparam int CNT_W         = ES_DATA_WIDTH * ES_NUM_INPUTS;

  function automatic int stream_len(input int n, input int k);
    return 1 << (n * k);
  endfunction

endpackage

// File: rtl/es_digit_cmp.sv
// One operand's stream bit: its counter digit compared against the latched operand.
module es_digit_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] digit,
  input  logic [W-1:0] operand,
  output logic         lt
);

  assign lt = digit < operand;

endmodule

// File: rtl/es_ordered_bs_gen.sv
// Ordered bitstream encoder: operand i compares against counter digit i, so each
// stream runs at its own clock-division rate and the AND of all streams is exact.
module es_ordered_bs_gen
  import es_bs_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   start,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  bin_data_in,
  output logic [NUM_INPUTS-1:0]                  bs_out,
  output logic                                   bs_valid,
  output logic                                   bs_last,
  output logic                                   busy,
  output logic                                   done
);

  localparam int             CW   = DATA_WIDTH * NUM_INPUTS;
  localparam logic [CW-1:0]  LAST = '1;

  es_gen_state_t                          state;
  logic [CW-1:0]                          cnt;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  op_reg;
  logic [NUM_INPUTS-1:0]                  cmp_bit;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cmp
    es_digit_cmp #(.W(DATA_WIDTH)) u_cmp (
      .digit   (cnt[i*DATA_WIDTH +: DATA_WIDTH]),
      .operand (op_reg[i]),
      .lt      (cmp_bit[i])
    );
  end

  // DONE spans two cycles: the first arms the done pulse, the second shows it
  // while busy is still high, so a new start is only seen after busy drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_reg   <= '0;
      bs_out   <= '0;
      bs_valid <= 1'b0;
      bs_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bs_valid <= 1'b0;
          bs_last  <= 1'b0;
          if (start) begin
            op_reg <= bin_data_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            bs_out   <= cmp_bit;
            bs_valid <= 1'b1;
            bs_last  <= (cnt == LAST);
            cnt      <= cnt + 1'b1;
            if (cnt == LAST) state <= DONE;
          end else begin
            bs_valid <= 1'b0;
            bs_last  <= 1'b0;
          end
        end
        DONE: begin
          bs_valid <= 1'b0;
          bs_last  <= 1'b0;
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_es_ordered_bs_gen.sv
// Scoreboard bench: a small N=2 instance for directed timing/stream checks and
// an N=5 instance for randomized popcount checks.
module tb_es_ordered_bs_gen;
  import es_bs_pkg::*;

  localparam int NA    = 2;
  localparam int NB    = 5;
  localparam int K     = 2;
  localparam int LEN_A = stream_len(NA, K);
  localparam int LEN_B = stream_len(NB, K);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                 en_a = 1'b0, start_a = 1'b0;
  logic [K-1:0][NA-1:0] din_a = '0;
  logic [K-1:0]         bs_a;
  logic                 vld_a, last_a, busy_a, done_a;

  logic                 en_b = 1'b0, start_b = 1'b0;
  logic [K-1:0][NB-1:0] din_b = '0;
  logic [K-1:0]         bs_b;
  logic                 vld_b, last_b, busy_b, done_b;

  int checks = 0, errors = 0, cyc = 0;
  logic [2:0] qa[$], qb[$];
  logic [2:0] ea, eb;
  int pa0 = 0, pa1 = 0, pan = 0, done_n_a = 0, done_cyc_a = 0;
  int pb0 = 0, pb1 = 0, pbn = 0, done_n_b = 0;
  logic [15:0] sa0 = '0, sa1 = '0;

  es_ordered_bs_gen #(.DATA_WIDTH(NA), .NUM_INPUTS(K)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .start(start_a), .bin_data_in(din_a),
    .bs_out(bs_a), .bs_valid(vld_a), .bs_last(last_a), .busy(busy_a), .done(done_a)
  );

  es_ordered_bs_gen #(.DATA_WIDTH(NB), .NUM_INPUTS(K)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .start(start_b), .bin_data_in(din_b),
    .bs_out(bs_b), .bs_valid(vld_b), .bs_last(last_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2:0] exp_bits(input int n, input int v0, input int v1,
                                          input int j, input int len);
    int m;
    m = (1 << n) - 1;
    return {j == len - 1, ((j >> n) & m) < v1, (j & m) < v0};
  endfunction

  always @(negedge clk) begin
    if (vld_a) begin
      if (qa.size() == 0) chk("a_extra_bit", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_bit", {last_a, bs_a}, ea);
      end
      sa0 = {bs_a[0], sa0[15:1]};
      sa1 = {bs_a[1], sa1[15:1]};
      pa0 += int'(bs_a[0]); pa1 += int'(bs_a[1]); pan += int'(&bs_a);
    end else if (last_a) chk("a_last_no_valid", 1, 0);
    if (done_a) begin
      done_n_a++;
      done_cyc_a = cyc;
      chk("a_done_cycle_quiet", {vld_a, last_a, busy_a}, 3'b001);
    end
  end

  always @(negedge clk) begin
    if (vld_b) begin
      if (qb.size() == 0) chk("b_extra_bit", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_bit", {last_b, bs_b}, eb);
      end
      pb0 += int'(bs_b[0]); pb1 += int'(bs_b[1]); pbn += int'(&bs_b);
    end else if (last_b) chk("b_last_no_valid", 1, 0);
    if (done_b) done_n_b++;
  end

  task automatic run_a(input int v0, input int v1, input bit tog,
                       output int lat, output int p0, output int p1, output int pn);
    int k, d0, s0, s1, sn;
    @(posedge clk); #1;
    for (int j = 0; j < LEN_A; j++) qa.push_back(exp_bits(NA, v0, v1, j, LEN_A));
    din_a[0] = NA'(v0); din_a[1] = NA'(v1);
    start_a = 1'b1; en_a = 1'b1;
    k = cyc; d0 = done_n_a; s0 = pa0; s1 = pa1; sn = pan;
    @(posedge clk); #1;
    start_a = 1'b0;
    if (tog) en_a = 1'b0;
    chk("a_busy_rise", busy_a, 1);
    for (int t = 0; t < 200 && done_n_a == d0; t++) begin
      @(posedge clk); #1;
      if (tog) en_a = ~en_a;
    end
    chk("a_done_seen", done_n_a - d0, 1);
    chk("a_busy_fall", busy_a, 0);
    en_a = 1'b1;
    lat = done_cyc_a - k;
    p0 = pa0 - s0; p1 = pa1 - s1; pn = pan - sn;
  endtask

  task automatic run_b(input int v0, input int v1);
    int d0, s0, s1, sn;
    @(posedge clk); #1;
    for (int j = 0; j < LEN_B; j++) qb.push_back(exp_bits(NB, v0, v1, j, LEN_B));
    din_b[0] = NB'(v0); din_b[1] = NB'(v1);
    start_b = 1'b1; en_b = 1'b1;
    d0 = done_n_b; s0 = pb0; s1 = pb1; sn = pbn;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int t = 0; t < LEN_B + 20 && done_n_b == d0; t++) begin
      @(posedge clk); #1;
    end
    chk("b_done_seen", done_n_b - d0, 1);
    chk("b_pop0", pb0 - s0, v0 * 32);
    chk("b_pop1", pb1 - s1, v1 * 32);
    chk("b_pop_and", pbn - sn, v0 * v1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, p0, p1, pn, k, d0, v0, v1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {bs_a, vld_a, last_a, busy_a, done_a}, 0);
    chk("reset_b", {bs_b, vld_b, last_b, busy_b, done_b}, 0);
    rst = 1'b0;

    // 3,2 continuous
    run_a(3, 2, 1'b0, lat, p0, p1, pn);
    chk("s1_stream0", sa0, 16'h7777);
    chk("s1_stream1", sa1, 16'h00FF);
    chk("s1_pop_and", pn, 6);
    chk("s1_done_lat", lat, 18);

    // zero operand
    run_a(0, 3, 1'b0, lat, p0, p1, pn);
    chk("s2_pop0", p0, 0);
    chk("s2_pop1", p1, 12);
    chk("s2_pop_and", pn, 0);

    // en toggling
    run_a(2, 1, 1'b1, lat, p0, p1, pn);
    chk("s3_stream0", sa0, 16'h3333);
    chk("s3_stream1", sa1, 16'h000F);
    chk("s3_done_lat", lat, 34);

    // reset at bit 7
    @(posedge clk); #1;
    for (int j = 0; j < LEN_A; j++) qa.push_back(exp_bits(NA, 3, 1, j, LEN_A));
    din_a[0] = 2'd3; din_a[1] = 2'd1; start_a = 1'b1; en_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("s4_bit7_valid", vld_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    chk("s4_rst_outs", {bs_a, vld_a, last_a, busy_a, done_a}, 0);
    d0 = done_n_a;
    repeat (25) @(posedge clk);
    #1;
    chk("s4_no_done", done_n_a - d0, 0);
    run_a(1, 2, 1'b0, lat, p0, p1, pn);
    chk("s4_pop0", p0, 4);
    chk("s4_pop1", p1, 8);
    chk("s4_pop_and", pn, 2);

    // start held high, operands changed mid-run
    @(posedge clk); #1;
    for (int j = 0; j < LEN_A; j++) qa.push_back(exp_bits(NA, 2, 3, j, LEN_A));
    din_a[0] = 2'd2; din_a[1] = 2'd3; start_a = 1'b1; en_a = 1'b1;
    k = cyc; d0 = done_n_a;
    repeat (5) @(posedge clk);
    #1;
    din_a[0] = 2'd1; din_a[1] = 2'd1;
    for (int j = 0; j < LEN_A; j++) qa.push_back(exp_bits(NA, 1, 1, j, LEN_A));
    for (int t = 0; t < 100 && done_n_a == d0; t++) begin
      @(posedge clk); #1;
    end
    chk("s5_first_done", done_cyc_a - k, 18);
    chk("s5_idle_busy", busy_a, 0);
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("s5_rerun_busy", busy_a, 1);
    for (int t = 0; t < 100 && done_n_a == d0 + 1; t++) begin
      @(posedge clk); #1;
    end
    chk("s5_second_done", done_cyc_a - k, 37);

    // randomized N=5 runs with boundary operands first
    for (int r = 0; r < 20; r++) begin
      v0 = (r == 0) ? 0 : (r == 1) ? 31 : int'($urandom_range(0, 31));
      v1 = (r == 0) ? 31 : (r == 1) ? 31 : int'($urandom_range(0, 31));
      run_b(v0, v1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
